// File: rtl/param_serial_receiver.sv
// -----------------------------------------------------------------------------
// param_serial_receiver
//
// Frame-synchronised serial receiver feeding a small show-ahead FIFO.
// A one-cycle high pulse on sspfssin starts a frame. The next DATA_WIDTH
// rising edges sample ssprxd into a shift register. The word is then pushed
// into the FIFO on the edge that leaves the STORE state. The consumer reads
// the head word directly from ssprxout and pops it with rd_ack.
//
// Optional feature (macro SERIAL_RX_PARITY_EN):
//   One even-parity bit follows the data bits. A per-entry error flag is
//   stored with every word, and rx_parity_err shows the flag of the head word.
//
// Parameters:
//   DATA_WIDTH : bits per word (4..16)
//   FIFO_DEPTH : FIFO entries (power of two, 2..32)
//   MSB_FIRST  : 1 -> first serial bit is word bit DATA_WIDTH-1,
//                0 -> first serial bit is word bit 0
//
// Ports:
//   sspclkin      in   single clock, rising edge
//   rst_i         in   synchronous active-high reset
//   sspfssin      in   frame sync pulse preceding the first data bit
//   ssprxd        in   serial data
//   rd_ack        in   pop request for the head word
//   ssprxout      out  FIFO head word (0 when empty)
//   valid_data    out  FIFO non-empty
//   fifo_level    out  number of stored words
//   rx_overrun    out  sticky: a completed word was dropped (FIFO full)
//   rx_parity_err out  parity error flag of the head word (macro only)
// -----------------------------------------------------------------------------
module param_serial_receiver #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int MSB_FIRST  = 1
) (
    input  logic                             sspclkin,
    input  logic                             rst_i,
    input  logic                             sspfssin,
    input  logic                             ssprxd,
    input  logic                             rd_ack,
    output logic [DATA_WIDTH-1:0]            ssprxout,
    output logic                             valid_data,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_level,
    output logic                             rx_overrun
`ifdef SERIAL_RX_PARITY_EN
    ,
    output logic                             rx_parity_err
`endif
);

    localparam int LW = $clog2(FIFO_DEPTH + 1);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(DATA_WIDTH);

    localparam logic [PW-1:0] PTR_ONE  = PW'(1);
    localparam logic [LW-1:0] LVL_ONE  = LW'(1);
    localparam logic [LW-1:0] LVL_FULL = LW'(FIFO_DEPTH);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
`ifdef SERIAL_RX_PARITY_EN
        ST_PARITY = 2'd2,
`endif
        ST_STORE  = 2'd3
    } state_t;

    // Insert one serial bit into the word according to the configured order.
    function automatic logic [DATA_WIDTH-1:0] shift_in(
        input logic [DATA_WIDTH-1:0] cur,
        input logic                  bit_in
    );
        logic [DATA_WIDTH-1:0] nxt;
        if (MSB_FIRST != 0) begin
            nxt = {cur[DATA_WIDTH-2:0], bit_in};
        end else begin
            nxt = {bit_in, cur[DATA_WIDTH-1:1]};
        end
        return nxt;
    endfunction

`ifdef SERIAL_RX_PARITY_EN
    // Even parity: data ones plus the parity bit must be an even count.
    function automatic logic even_parity_err(
        input logic [DATA_WIDTH-1:0] data,
        input logic                  par_bit
    );
        return (^data) ^ par_bit;
    endfunction
`endif

    // Frame sequencer state
    state_t                  state_r;
    logic [CW-1:0]           bit_cnt_r;
    logic [DATA_WIDTH-1:0]   shift_r;

    // FIFO state
    logic [DATA_WIDTH-1:0]   mem_r [FIFO_DEPTH];
    logic [PW-1:0]           wr_ptr_r;
    logic [PW-1:0]           rd_ptr_r;
    logic [LW-1:0]           level_r;
    logic                    overrun_r;
    logic [DATA_WIDTH-1:0]   head_data_r;
    logic                    head_valid_r;

    // FIFO next-state signals
    logic                    push_s;
    logic                    pop_s;
    logic                    full_s;
    logic                    wr_en_s;
    logic [PW-1:0]           rd_ptr_nxt_s;
    logic [LW-1:0]           remain_s;
    logic [LW-1:0]           level_nxt_s;
    logic                    overrun_nxt_s;
    logic [DATA_WIDTH-1:0]   head_data_nxt_s;

`ifdef SERIAL_RX_PARITY_EN
    logic                    par_err_r;
    logic                    err_mem_r [FIFO_DEPTH];
    logic                    head_err_r;
    logic                    head_err_nxt_s;
`endif

    // Frame sequencer: state, bit counter, shift register and parity capture.
    always_ff @(posedge sspclkin) begin
        if (rst_i) begin
            state_r   <= ST_IDLE;
            bit_cnt_r <= '0;
            shift_r   <= '0;
`ifdef SERIAL_RX_PARITY_EN
            par_err_r <= 1'b0;
`endif
        end else begin
            case (state_r)
                ST_IDLE: begin
                    // Serial data is ignored until a frame sync is seen.
                    bit_cnt_r <= '0;
                    if (sspfssin) begin
                        state_r <= ST_SHIFT;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_SHIFT: begin
                    shift_r <= shift_in(shift_r, ssprxd);
                    if (bit_cnt_r == CNT_LAST) begin
                        // The counter is cleared here so it never wraps mid-frame.
                        bit_cnt_r <= '0;
`ifdef SERIAL_RX_PARITY_EN
                        state_r   <= ST_PARITY;
`else
                        state_r   <= ST_STORE;
`endif
                    end else begin
                        bit_cnt_r <= bit_cnt_r + CNT_ONE;
                        state_r   <= ST_SHIFT;
                    end
                end
`ifdef SERIAL_RX_PARITY_EN
                ST_PARITY: begin
                    par_err_r <= even_parity_err(shift_r, ssprxd);
                    state_r   <= ST_STORE;
                end
`endif
                ST_STORE: begin
                    // The word is pushed as this state is left. A sync pulse here
                    // chains the next frame with no idle gap.
                    bit_cnt_r <= '0;
                    if (sspfssin) begin
                        state_r <= ST_SHIFT;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    bit_cnt_r <= '0;
                end
            endcase
        end
    end

    // FIFO next state: qualify push/pop, advance pointers and compute the next head.
    always_comb begin
        push_s          = (state_r == ST_STORE);
        pop_s           = rd_ack && (level_r != '0);
        full_s          = (level_r == LVL_FULL);
        wr_en_s         = 1'b0;
        rd_ptr_nxt_s    = rd_ptr_r;
        remain_s        = level_r;
        level_nxt_s     = level_r;
        overrun_nxt_s   = overrun_r;
        head_data_nxt_s = '0;

        // A pop on the same edge frees the slot, so a push to a full FIFO succeeds.
        if (push_s && (pop_s || !full_s)) begin
            wr_en_s = 1'b1;
        end else begin
            wr_en_s = 1'b0;
        end

        if (push_s && !pop_s && full_s) begin
            overrun_nxt_s = 1'b1;
        end else begin
            overrun_nxt_s = overrun_r;
        end

        if (pop_s) begin
            rd_ptr_nxt_s = rd_ptr_r + PTR_ONE;
            remain_s     = level_r - LVL_ONE;
        end else begin
            rd_ptr_nxt_s = rd_ptr_r;
            remain_s     = level_r;
        end

        if (wr_en_s) begin
            level_nxt_s = remain_s + LVL_ONE;
        end else begin
            level_nxt_s = remain_s;
        end

        // When nothing remains after the pop, the new head can only be the word
        // written on this edge. Otherwise the entry at the next read pointer is
        // the head; this edge never overwrites that entry.
        if (wr_en_s && (remain_s == '0)) begin
            head_data_nxt_s = shift_r;
        end else if (remain_s == '0) begin
            head_data_nxt_s = '0;
        end else begin
            head_data_nxt_s = mem_r[rd_ptr_nxt_s];
        end
    end

`ifdef SERIAL_RX_PARITY_EN
    // Head parity flag follows the same selection as the head word.
    always_comb begin
        head_err_nxt_s = 1'b0;
        if (wr_en_s && (remain_s == '0)) begin
            head_err_nxt_s = par_err_r;
        end else if (remain_s == '0) begin
            head_err_nxt_s = 1'b0;
        end else begin
            head_err_nxt_s = err_mem_r[rd_ptr_nxt_s];
        end
    end
`endif

    // FIFO control registers and registered head outputs.
    always_ff @(posedge sspclkin) begin
        if (rst_i) begin
            wr_ptr_r     <= '0;
            rd_ptr_r     <= '0;
            level_r      <= '0;
            overrun_r    <= 1'b0;
            head_data_r  <= '0;
            head_valid_r <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
            head_err_r   <= 1'b0;
`endif
        end else begin
            if (wr_en_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            rd_ptr_r     <= rd_ptr_nxt_s;
            level_r      <= level_nxt_s;
            overrun_r    <= overrun_nxt_s;
            head_data_r  <= head_data_nxt_s;
            head_valid_r <= (level_nxt_s != '0);
`ifdef SERIAL_RX_PARITY_EN
            head_err_r   <= head_err_nxt_s;
`endif
        end
    end

    // FIFO storage. Entries are not reset; the empty state hides them.
    always_ff @(posedge sspclkin) begin
        if (wr_en_s && !rst_i) begin
            mem_r[wr_ptr_r] <= shift_r;
`ifdef SERIAL_RX_PARITY_EN
            err_mem_r[wr_ptr_r] <= par_err_r;
`endif
        end
    end

    assign ssprxout   = head_data_r;
    assign valid_data = head_valid_r;
    assign fifo_level = level_r;
    assign rx_overrun = overrun_r;
`ifdef SERIAL_RX_PARITY_EN
    assign rx_parity_err = head_err_r;
`endif

endmodule

// File: tb/tb_param_serial_receiver.sv
// -----------------------------------------------------------------------------
// Bench for param_serial_receiver. Two instances share one set of inputs:
// one is MSB-first and one is LSB-first. A queue-based reference model
// predicts the contents of each FIFO from the serial bit order. All outputs
// are compared on every falling edge.
// -----------------------------------------------------------------------------
module tb_param_serial_receiver;

    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int LW    = $clog2(DEPTH + 1);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_i;
    logic fss;
    logic rxd;
    logic ack;

    logic [DW-1:0] out_m, out_l;
    logic          vld_m, vld_l;
    logic [LW-1:0] lvl_m, lvl_l;
    logic          ovr_m, ovr_l;
`ifdef SERIAL_RX_PARITY_EN
    logic          perr_m, perr_l;
`endif

    param_serial_receiver #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .MSB_FIRST(1)) dut_msb (
        .sspclkin   (clk),
        .rst_i      (rst_i),
        .sspfssin   (fss),
        .ssprxd     (rxd),
        .rd_ack     (ack),
        .ssprxout   (out_m),
        .valid_data (vld_m),
        .fifo_level (lvl_m),
        .rx_overrun (ovr_m)
`ifdef SERIAL_RX_PARITY_EN
        ,
        .rx_parity_err (perr_m)
`endif
    );

    param_serial_receiver #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .MSB_FIRST(0)) dut_lsb (
        .sspclkin   (clk),
        .rst_i      (rst_i),
        .sspfssin   (fss),
        .ssprxd     (rxd),
        .rd_ack     (ack),
        .ssprxout   (out_l),
        .valid_data (vld_l),
        .fifo_level (lvl_l),
        .rx_overrun (ovr_l)
`ifdef SERIAL_RX_PARITY_EN
        ,
        .rx_parity_err (perr_l)
`endif
    );

    int total = 0;
    int bad   = 0;

    // Reference model: one queue of words per bit order plus parity flags.
    logic [DW-1:0] q_m[$];
    logic [DW-1:0] q_l[$];
    logic          q_e[$];
    logic          ovr_exp = 1'b0;
    logic [DW-1:0] cur_m, cur_l;
    logic          cur_e;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        logic [DW-1:0] hm, hl;
        logic          he;
        if (q_m.size() > 0) begin
            hm = q_m[0];
            hl = q_l[0];
            he = q_e[0];
        end else begin
            hm = '0;
            hl = '0;
            he = 1'b0;
        end
        check("valid_msb", 32'(vld_m), 32'(q_m.size() > 0));
        check("head_msb",  32'(out_m), 32'(hm));
        check("level_msb", 32'(lvl_m), 32'(q_m.size()));
        check("ovr_msb",   32'(ovr_m), 32'(ovr_exp));
        check("valid_lsb", 32'(vld_l), 32'(q_l.size() > 0));
        check("head_lsb",  32'(out_l), 32'(hl));
        check("level_lsb", 32'(lvl_l), 32'(q_l.size()));
        check("ovr_lsb",   32'(ovr_l), 32'(ovr_exp));
`ifdef SERIAL_RX_PARITY_EN
        check("perr_msb",  32'(perr_m), 32'(he));
        check("perr_lsb",  32'(perr_l), 32'(he));
`else
        he = he;
`endif
    endtask

    // One clock cycle: drive inputs, update the model at the rising edge,
    // then compare on the falling edge.
    task automatic cyc(input logic f, input logic d, input logic a, input bit push, input logic r);
        logic popping;
        rst_i = r;
        fss   = f;
        rxd   = d;
        ack   = a;
        @(posedge clk);
        if (r) begin
            q_m.delete();
            q_l.delete();
            q_e.delete();
            ovr_exp = 1'b0;
        end else begin
            popping = a && (q_m.size() > 0);
            if (popping) begin
                void'(q_m.pop_front());
                void'(q_l.pop_front());
                void'(q_e.pop_front());
            end
            if (push) begin
                if (q_m.size() < DEPTH) begin
                    q_m.push_back(cur_m);
                    q_l.push_back(cur_l);
                    q_e.push_back(cur_e);
                end else begin
                    ovr_exp = 1'b1;
                end
            end
        end
        @(negedge clk);
        check_all();
    endtask

    task automatic idle(input int n, input bit rand_ack);
        for (int i = 0; i < n; i++) begin
            cyc(1'b0, 1'($urandom_range(0, 1)),
                rand_ack ? 1'($urandom_range(0, 1)) : 1'b0, 1'b0, 1'b0);
        end
    endtask

    // Send one frame. stream_w gives the serial order: its bit DW-1 is sent first.
    task automatic send_frame(input logic [DW-1:0] stream_w, input logic pbit, input bit first_fss,
                              input logic next_fss, input logic store_ack, input bit rand_ack);
        int vm, vl, ones, b;
        if (first_fss) begin
            cyc(1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0);
        end
        for (int i = 0; i < DW; i++) begin
            cyc(1'($urandom_range(0, 1)), stream_w[DW-1-i],
                rand_ack ? 1'($urandom_range(0, 7) == 0) : 1'b0, 1'b0, 1'b0);
        end
`ifdef SERIAL_RX_PARITY_EN
        cyc(1'($urandom_range(0, 1)), pbit,
            rand_ack ? 1'($urandom_range(0, 7) == 0) : 1'b0, 1'b0, 1'b0);
`endif
        vm = 0;
        vl = 0;
        ones = 0;
        for (int i = 0; i < DW; i++) begin
            b    = int'(stream_w[DW-1-i]);
            vm   = vm * 2 + b;
            vl   = vl + b * (1 << i);
            ones = ones + b;
        end
        cur_m = DW'(vm);
        cur_l = DW'(vl);
        cur_e = ((ones + int'(pbit)) % 2) != 0;
        cyc(next_fss, 1'($urandom_range(0, 1)), store_ack, 1'b1, 1'b0);
    endtask

    logic          chain;
    logic          nf;
    logic [DW-1:0] w;
    logic          pb;

    initial begin
        rst_i = 1'b1;
        fss   = 1'b0;
        rxd   = 1'b0;
        ack   = 1'b0;
        @(negedge clk);

        // Reset, including reset winning over sync and pop.
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);

        // Idle with toggling data and pops while empty.
        for (int i = 0; i < 8; i++) begin
            cyc(1'b0, 1'(i % 2), 1'(i % 3 == 0), 1'b0, 1'b0);
        end

        // Single frames in both bit orders, each popped afterwards.
        send_frame(8'hA5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        send_frame(8'hC0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

        // Five back-to-back frames overflow a four-entry FIFO, then drain it.
        for (int k = 1; k <= 5; k++) begin
            send_frame(DW'(k), 1'b0, k == 1, 1'(k < 5), 1'b0, 1'b0);
        end
        for (int k = 0; k < 5; k++) begin
            cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        end

        // Full FIFO with a pop on the fifth push edge: no overrun.
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int k = 1; k <= 5; k++) begin
            send_frame(DW'(16 + k), 1'b0, k == 1, 1'(k < 5), 1'(k == 5), 1'b0);
        end
        for (int k = 0; k < 5; k++) begin
            cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        end

        // Reset while a word is stored and sync/pop are high; nothing may start.
        send_frame(8'h77, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        idle(12, 1'b0);

        // Reset after four bits of a frame, then two clean 0x3C frames.
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        end
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        send_frame(8'h3C, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(2, 1'b0);
        send_frame(8'h3C, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

        // Random frames, random chaining, gaps and pops.
        chain = 1'b0;
        for (int k = 0; k < 24; k++) begin
            w  = DW'($urandom);
            pb = (^w) ^ 1'($urandom_range(0, 3) == 0);
            nf = (k < 23) && ($urandom_range(0, 1) == 1);
            send_frame(w, pb, !chain, nf, 1'($urandom_range(0, 1)), 1'b1);
            chain = nf;
            if (!nf) begin
                idle($urandom_range(0, 3), 1'b1);
            end
        end
        for (int k = 0; k < 5; k++) begin
            cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/param_serial_receiver.md
PARAM_SERIAL_RECEIVER -- requirements
Module: param_serial_receiver

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, bits per received word (legal range 4..16).
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 4, number of receive FIFO entries (power of two, 2..32).
REQ-003 The block SHALL have parameter MSB_FIRST, default 1: 1 means the first serial bit is word bit DATA_WIDTH-1; 0 means the first serial bit is bit 0.
REQ-004 The block SHALL have the port sspclkin, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have the port rst_i, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have the port sspfssin, input, 1 bit: frame sync, a one-cycle high pulse preceding the first data bit.
REQ-007 The block SHALL have the port ssprxd, input, 1 bit: serial data.
REQ-008 The block SHALL have the port rd_ack, input, 1 bit: consumer pop request for the head word.
REQ-009 The block SHALL have the port ssprxout, output, DATA_WIDTH bits: the FIFO head word.
REQ-010 The block SHALL have the port valid_data, output, 1 bit: high when the FIFO is non-empty.
REQ-011 The block SHALL have the port fifo_level, output, $clog2(FIFO_DEPTH+1) bits: the number of stored words.
REQ-012 The block SHALL have the port rx_overrun, output, 1 bit: sticky flag for a dropped word.

Function
REQ-013 The block SHALL implement a state machine with states IDLE, SHIFT, PARITY (macro only) and STORE.
REQ-014 In IDLE, sspfssin sampled high at edge T0 SHALL move the state to SHIFT; ssprxd SHALL be ignored in IDLE.
REQ-015 In SHIFT, ssprxd SHALL be sampled at edges T1..T(DATA_WIDTH) into a shift register ordered per MSB_FIRST, with a bit counter that counts 0..DATA_WIDTH-1 and never wraps mid-frame.
REQ-016 sspfssin SHALL be ignored in SHIFT and PARITY.
REQ-017 After the last data bit (or the parity bit) the state SHALL be STORE for exactly one cycle, pushing the word at the edge that leaves STORE.
REQ-018 valid_data and ssprxout SHALL reflect the pushed word in the cycle after that edge (T(DATA_WIDTH+1) without the macro).
REQ-019 sspfssin high during STORE SHALL start the next frame directly (STORE to SHIFT); otherwise the state SHALL go to IDLE.
REQ-020 The FIFO SHALL be show-ahead: ssprxout equals the head word when valid_data=1, and 0 when the FIFO is empty.
REQ-021 rd_ack high with valid_data=1 SHALL pop one word at that edge; rd_ack while empty SHALL be ignored, with no underflow and no state change.
REQ-022 A push and a pop on the same edge SHALL both complete, with fifo_level unchanged, including when the FIFO is full (no overrun).
REQ-023 A push while full without a pop SHALL drop the new word, leave the FIFO contents unchanged, and set rx_overrun, which stays set until reset.
REQ-024 The read and write pointers SHALL wrap modulo FIFO_DEPTH; fifo_level SHALL saturate at 0 and FIFO_DEPTH by construction.

Reset
REQ-025 rst_i high at a rising edge SHALL force the state to IDLE, clear the bit counter, shift register and FIFO pointers, and drive ssprxout=0, valid_data=0, fifo_level=0, rx_overrun=0 (and rx_parity_err=0).
REQ-026 Reset mid-frame SHALL discard the partial word.
REQ-027 Reset SHALL override a simultaneous sspfssin or rd_ack.

Configuration
REQ-028 When the macro SERIAL_RX_PARITY_EN is defined, one even-parity bit SHALL follow the data bits and be sampled in state PARITY.
REQ-029 When SERIAL_RX_PARITY_EN is defined, a per-entry error flag SHALL be stored with each FIFO word, and output port rx_parity_err (1 bit) SHALL give the flag of the head word (0 when empty).
REQ-030 When SERIAL_RX_PARITY_EN is not defined, the PARITY state and the rx_parity_err port SHALL be absent, and a frame SHALL be DATA_WIDTH bits.

Verification (DATA_WIDTH=8, FIFO_DEPTH=4, MSB_FIRST=1 unless stated)
REQ-031 Reset, then idle with ssprxd toggling -> ssprxout=0, valid_data=0, fifo_level=0, rx_overrun=0 throughout.
REQ-032 sspfssin pulse, then serial 1,0,1,0,0,1,0,1 -> valid_data=1 and ssprxout=0xA5 nine cycles after the sspfssin edge; a one-cycle rd_ack -> valid_data=0 next cycle.
REQ-033 MSB_FIRST=0, same bit stream -> ssprxout=0xA5 (bit-reversed 0xA5 = 0xA5); the stream 1,1,0,0,0,0,0,0 -> ssprxout=0x03.
REQ-034 Five back-to-back frames 0x01..0x05 with no rd_ack -> fifo_level=4, rx_overrun=1, ssprxout=0x01; then four pops -> 0x02, 0x03, 0x04 in sequence, then empty.
REQ-035 FIFO full and rd_ack asserted on the edge of the fifth push -> fifo_level stays 4, rx_overrun=0, and the fifth word is retained at the tail.
REQ-036 rst_i pulsed after 4 bits of a frame, then a new frame 0x3C -> only 0x3C is received; with SERIAL_RX_PARITY_EN, frame 0x3C with parity bit 1 -> rx_parity_err=1, and with parity bit 0 -> rx_parity_err=0.
